// File: rtl/mpu_frame_sequencer_pkg.sv
// Shared types for the MPU frame sequencer: FSM states,
// response status codes, frame header defaults and frame helpers.
package mpu_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_OP,
    GET_A,
    GET_B,
    GET_CK,
    ALU_RUN,
    TX_LOAD,
    TX_WAIT
  } state_e;

  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_CKSUM  = 8'h01;
  localparam logic [7:0] ST_ALU_TO = 8'h03;
  localparam logic [7:0] ST_BADOP  = 8'h04;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hAA;
  localparam logic [7:0] RESP_BYTE_DEF = 8'h55;

  // Checksum failure outranks an illegal opcode.
  function automatic logic [7:0] frame_status(
    input logic [7:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] ck
  );
    if (ck != (op ^ a ^ b))
      return ST_CKSUM;
    else if (op[7:4] != 4'h0)
      return ST_BADOP;
    else
      return ST_OK;
  endfunction

  function automatic logic [7:0] resp_byte(
    input logic [1:0]  idx,
    input logic [7:0]  hdr,
    input logic [7:0]  st,
    input logic [15:0] res
  );
    unique case (idx)
      2'd0: return hdr;
      2'd1: return st;
      2'd2: return res[15:8];
      2'd3: return res[7:0];
    endcase
  endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Loadable down-counter with a one-cycle expiry pulse.
// Ports: clk, rst_n, load_i (reload to LOAD), en_i (count), expire_o.
module frame_timeout_counter #(
  parameter int WIDTH = 8,
  parameter int LOAD  = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (load_i)
      cnt_q <= WIDTH'(LOAD);
    else if (en_i && cnt_q != '0)
      cnt_q <= cnt_q - WIDTH'(1);
  end

  // Fires on the LOAD-th enabled cycle after a reload; a
  // reload in the same cycle suppresses it.
  assign expire_o = en_i && !load_i &&
                    (cnt_q == WIDTH'(1));

endmodule

// File: rtl/mpu_frame_sequencer.sv
// Framed command sequencer: UART rx frame -> ALU -> UART tx frame.
// Ports: clk/rst_n; rx_data/rx_complete/rx_error from UART rx;
// alu_op/alu_a/alu_b/alu_start to ALU, alu_result/alu_done back;
// txd/tx_en to UART tx, tx_complete back; busy; err_cnt.
module mpu_frame_sequencer
  import mpu_frame_sequencer_pkg::*;
#(
  parameter int         SYS_CLK       = 50000000,
  parameter int         BAUD_RATE     = 115200,
  parameter int         TIMEOUT_BYTES = 4,
  parameter int         ALU_WAIT_MAX  = 255,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
  parameter logic [7:0] RESP_BYTE     = RESP_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_complete,
  input  logic        rx_error,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_start,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  output logic [7:0]  txd,
  output logic        tx_en,
  input  logic        tx_complete,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int TO_CYCLES =
    (SYS_CLK / BAUD_RATE) * 10 * TIMEOUT_BYTES;
  localparam int TO_W = $clog2(TO_CYCLES + 1);
  localparam int WD_W = $clog2(ALU_WAIT_MAX + 1);

  state_e      state_q;
  logic [7:0]  op_q, a_q, b_q;
  logic [7:0]  status_q;
  logic [15:0] res_q;
  logic [1:0]  idx_q;
  logic [3:0]  alu_op_q;
  logic [7:0]  alu_a_q, alu_b_q;
  logic        alu_start_q;
  logic [7:0]  txd_q;
  logic        tx_en_q;
  logic        busy_q;
  logic [7:0]  err_cnt_q;

  logic       in_get;
  logic       byte_ok;
  logic       to_load, to_expire;
  logic       wd_load, wd_expire;
  logic [7:0] ck_status;
  logic [7:0] err_cnt_sat;

  // rx_error in the same cycle discards the byte.
  assign byte_ok = rx_complete && !rx_error;
  assign in_get  = (state_q == GET_OP) || (state_q == GET_A) ||
                   (state_q == GET_B)  || (state_q == GET_CK);

  assign to_load = in_get ? byte_ok :
                   (state_q == IDLE) && byte_ok &&
                   (rx_data == SYNC_BYTE);
  assign wd_load = (state_q == GET_CK) && byte_ok;

  assign ck_status   = frame_status(op_q, a_q, b_q, rx_data);
  assign err_cnt_sat = (err_cnt_q == 8'hFF) ? 8'hFF
                                            : err_cnt_q + 8'd1;

  frame_timeout_counter #(
    .WIDTH (TO_W),
    .LOAD  (TO_CYCLES)
  ) u_byte_to (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (to_load),
    .en_i     (in_get),
    .expire_o (to_expire)
  );

  frame_timeout_counter #(
    .WIDTH (WD_W),
    .LOAD  (ALU_WAIT_MAX)
  ) u_alu_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (wd_load),
    .en_i     (state_q == ALU_RUN),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      status_q    <= '0;
      res_q       <= '0;
      idx_q       <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_start_q <= 1'b0;
      txd_q       <= '0;
      tx_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      alu_start_q <= 1'b0;
      tx_en_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (byte_ok && rx_data == SYNC_BYTE) begin
            state_q <= GET_OP;
            busy_q  <= 1'b1;
          end
        end
        GET_OP, GET_A, GET_B, GET_CK: begin
          if (rx_error || to_expire) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            err_cnt_q <= err_cnt_sat;
          end else if (rx_complete) begin
            if (state_q == GET_OP) begin
              op_q    <= rx_data;
              state_q <= GET_A;
            end else if (state_q == GET_A) begin
              a_q     <= rx_data;
              state_q <= GET_B;
            end else if (state_q == GET_B) begin
              b_q     <= rx_data;
              state_q <= GET_CK;
            end else begin
              idx_q <= 2'd0;
              if (ck_status == ST_OK) begin
                state_q     <= ALU_RUN;
                alu_start_q <= 1'b1;
                alu_op_q    <= op_q[3:0];
                alu_a_q     <= a_q;
                alu_b_q     <= b_q;
              end else begin
                status_q <= ck_status;
                res_q    <= '0;
                state_q  <= TX_LOAD;
                tx_en_q  <= 1'b1;
                txd_q    <= RESP_BYTE;
              end
            end
          end
        end
        ALU_RUN: begin
          // A completion in the expiry cycle still counts.
          if (alu_done) begin
            status_q <= ST_OK;
            res_q    <= alu_result;
            state_q  <= TX_LOAD;
            tx_en_q  <= 1'b1;
            txd_q    <= RESP_BYTE;
          end else if (wd_expire) begin
            status_q <= ST_ALU_TO;
            res_q    <= '0;
            state_q  <= TX_LOAD;
            tx_en_q  <= 1'b1;
            txd_q    <= RESP_BYTE;
          end
        end
        TX_LOAD: begin
          state_q <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_complete) begin
            if (idx_q == 2'd3) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + 2'd1;
              state_q <= TX_LOAD;
              tx_en_q <= 1'b1;
              txd_q   <= resp_byte(idx_q + 2'd1,
                                   RESP_BYTE,
                                   status_q, res_q);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_start = alu_start_q;
  assign txd       = txd_q;
  assign tx_en     = tx_en_q;
  assign busy      = busy_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mpu_frame_sequencer.sv
// Self-checking bench for mpu_frame_sequencer: vector table,
// corner sequences and random frames against a frame-level model.
module tb_mpu_frame_sequencer;

  localparam int SYS_CLK = 1152000;
  localparam int BAUD    = 115200;
  localparam int TOB     = 4;
  localparam int WMAX    = 255;
  localparam int TO_CYC  = (SYS_CLK / BAUD) * 10 * TOB;
  localparam int TX_LAT  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_complete = 1'b0;
  logic        rx_error = 1'b0;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a, alu_b;
  logic        alu_start;
  logic [15:0] alu_result = '0;
  logic        alu_done = 1'b0;
  logic [7:0]  txd;
  logic        tx_en;
  logic        tx_complete = 1'b0;
  logic        busy;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mpu_frame_sequencer #(
    .SYS_CLK       (SYS_CLK),
    .BAUD_RATE     (BAUD),
    .TIMEOUT_BYTES (TOB),
    .ALU_WAIT_MAX  (WMAX),
    .SYNC_BYTE     (8'hAA),
    .RESP_BYTE     (8'h55)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_complete (rx_complete),
    .rx_error    (rx_error),
    .alu_op      (alu_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_start   (alu_start),
    .alu_result  (alu_result),
    .alu_done    (alu_done),
    .txd         (txd),
    .tx_en       (tx_en),
    .tx_complete (tx_complete),
    .busy        (busy),
    .err_cnt     (err_cnt)
  );

  typedef struct {
    logic [39:0] frm;
    logic [31:0] rsp;
    int          nst;
  } vec_t;

  vec_t tbl[5];

  function automatic logic [15:0] alu_fn(
    input logic [3:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    case (op)
      4'd1:    return 16'(a) + 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      default: return {a, b} ^ 16'h5A5A;
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [39:0] act,
                     input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ALU and UART-tx responders plus event recorder.
  int          cyc = 0;
  int          starts = 0;
  int          start_cyc = 0, done_cyc = 0;
  int          first_txen_cyc = 0, txc_cyc = 0;
  int          alu_cnt = 0, tx_cnt = 0;
  int          alu_lat = 3;
  int          ck_cyc = 0;
  bit          alu_hang = 1'b0;
  logic [3:0]  cap_op;
  logic [7:0]  cap_a, cap_b, tx_hold;
  logic [7:0]  txq[$];

  always @(negedge clk) begin
    cyc++;
    alu_done    = 1'b0;
    tx_complete = 1'b0;
    if (!rst_n) begin
      alu_cnt = 0;
      tx_cnt  = 0;
    end else begin
      if (alu_cnt > 0) begin
        chk("alu_operands_stable",
            {alu_op, alu_a, alu_b},
            {cap_op, cap_a, cap_b});
        alu_cnt--;
        if (alu_cnt == 0) begin
          alu_done   = 1'b1;
          alu_result = alu_fn(cap_op, cap_a, cap_b);
          done_cyc   = cyc;
        end
      end
      if (alu_start) begin
        starts++;
        start_cyc = cyc;
        cap_op = alu_op;
        cap_a  = alu_a;
        cap_b  = alu_b;
        if (!alu_hang) alu_cnt = alu_lat;
      end
      if (tx_cnt > 0) begin
        chk("txd_stable", txd, tx_hold);
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_complete = 1'b1;
          txc_cyc = cyc;
        end
      end
      if (tx_en) begin
        if (txq.size() == 0)
          first_txen_cyc = cyc;
        else
          chk("tx_spacing", cyc - txc_cyc, 1);
        txq.push_back(txd);
        tx_hold = txd;
        tx_cnt  = TX_LAT;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    rx_complete = 1'b1;
    tick();
    rx_complete = 1'b0;
  endtask

  task automatic send_frame(input logic [39:0] f,
                            input int gap);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) ck_cyc = cyc;
      send_byte(f[39-8*i -: 8]);
      repeat (gap) tick();
    end
  endtask

  task automatic wait_idle(input string nm);
    for (int n = 0; n < 3000 && busy; n++) tick();
    chk({nm, "_idle"}, busy, 0);
  endtask

  task automatic run_frame(input logic [39:0] f,
                           input logic [31:0] rsp,
                           input int nst,
                           input int gap,
                           input string nm);
    int s0;
    logic [31:0] got;
    txq.delete();
    s0 = starts;
    send_frame(f, gap);
    wait_idle(nm);
    chk({nm, "_ntx"}, txq.size(), 4);
    if (txq.size() == 4) begin
      got = {txq[0], txq[1], txq[2], txq[3]};
      chk({nm, "_rsp"}, got, rsp);
    end
    chk({nm, "_starts"}, starts - s0, nst);
    if (nst == 1) begin
      chk({nm, "_lat_start"}, start_cyc - ck_cyc, 1);
      chk({nm, "_lat_tx"}, first_txen_cyc - done_cyc, 1);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, {busy, err_cnt, tx_en, txd, alu_start,
             alu_op, alu_a, alu_b}, 0);
  endtask

  initial begin
    int s0;
    int e;
    logic [7:0] op, a, b, ck, st, junk;
    logic [15:0] res;
    int gap;

    tbl[0] = '{frm: 40'hAA01123427, rsp: 32'h55000046, nst: 1};
    tbl[1] = '{frm: 40'hAA01123400, rsp: 32'h55010000, nst: 0};
    tbl[2] = '{frm: 40'hAA10123436, rsp: 32'h55040000, nst: 0};
    tbl[3] = '{frm: 40'hAA10123400, rsp: 32'h55010000, nst: 0};
    tbl[4] = '{frm: 40'hAA02FF03FE, rsp: 32'h550002FD, nst: 1};

    rst_n = 1'b0;
    repeat (3) tick();
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    tick();

    alu_lat = 3;
    for (int i = 0; i < 5; i++)
      run_frame(tbl[i].frm, tbl[i].rsp, tbl[i].nst, 0,
                $sformatf("vec%0d", i));
    chk("err_after_table", err_cnt, 0);

    // Inter-byte timeout after AA 01.
    txq.delete();
    s0 = starts;
    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (TO_CYC - 5) tick();
    chk("to_busy_before", busy, 1);
    repeat (10) tick();
    chk("to_busy_after", busy, 0);
    chk("to_err", err_cnt, 1);
    chk("to_ntx", txq.size(), 0);
    chk("to_starts", starts - s0, 0);

    // rx_error together with the 4th byte.
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h12);
    rx_data     = 8'h34;
    rx_complete = 1'b1;
    rx_error    = 1'b1;
    tick();
    rx_complete = 1'b0;
    rx_error    = 1'b0;
    repeat (3) tick();
    chk("rxerr_busy", busy, 0);
    chk("rxerr_err", err_cnt, 2);
    chk("rxerr_ntx", txq.size(), 0);
    rx_error = 1'b1;
    tick();
    rx_error = 1'b0;
    tick();
    chk("rxerr_idle_ignored", err_cnt, 2);

    // ALU hang with bytes injected during TX_WAIT.
    alu_hang = 1'b1;
    txq.delete();
    s0 = starts;
    send_frame(40'hAA01123427, 0);
    for (int n = 0; n < 400 && txq.size() == 0; n++) tick();
    chk("hang_txen_seen", txq.size() != 0, 1);
    chk("hang_watchdog_lat", first_txen_cyc - start_cyc, WMAX);
    tick();
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h12);
    wait_idle("hang");
    chk("hang_ntx", txq.size(), 4);
    if (txq.size() == 4)
      chk("hang_rsp", {txq[0], txq[1], txq[2], txq[3]},
          32'h55030000);
    chk("hang_starts", starts - s0, 1);
    alu_hang = 1'b0;
    repeat (5) tick();
    chk("hang_after_busy", busy, 0);
    chk("hang_err", err_cnt, 2);

    // Random frames against the frame-level model.
    for (int r = 0; r < 30; r++) begin
      op = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                       : 8'($urandom_range(0, 15));
      a  = 8'($urandom);
      b  = 8'($urandom);
      ck = op ^ a ^ b;
      if ($urandom_range(0, 3) == 0)
        ck = ck ^ 8'($urandom_range(1, 255));
      gap     = $urandom_range(0, 3);
      alu_lat = $urandom_range(1, 6);
      if ($urandom_range(0, 2) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'hAA) junk = 8'h00;
        send_byte(junk);
      end
      if (ck != (op ^ a ^ b))  st = 8'h01;
      else if (op[7:4] != 0)   st = 8'h04;
      else                     st = 8'h00;
      res = (st == 8'h00) ? alu_fn(op[3:0], a, b) : 16'h0;
      run_frame({8'hAA, op, a, b, ck}, {8'h55, st, res},
                (st == 8'h00) ? 1 : 0, gap,
                $sformatf("rnd%0d", r));
    end
    chk("err_after_rand", err_cnt, 2);

    // Asynchronous reset in TX_WAIT of the 2nd byte.
    alu_lat = 3;
    txq.delete();
    send_frame(tbl[4].frm, 0);
    for (int n = 0; n < 200 && txq.size() < 2; n++) tick();
    chk("rst_mid_reached", txq.size(), 2);
    tick();
    #1 rst_n = 1'b0;
    #1 chk_zero("rst_mid_async");
    tick();
    tick();
    chk_zero("rst_mid_held");
    rst_n = 1'b1;
    tick();
    run_frame(tbl[4].frm, tbl[4].rsp, 1, 1, "post_rst");
    chk("post_rst_err", err_cnt, 0);

    // Error counter saturation.
    e = 0;
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hAA);
      rx_error = 1'b1;
      tick();
      rx_error = 1'b0;
      e = (e == 255) ? 255 : e + 1;
    end
    tick();
    chk("err_saturate", err_cnt, e);
    chk("err_sat_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mpu_frame_sequencer.md
Name: mpu_frame_sequencer

Overview:
Framed command sequencer for the simple MPU, placed between the UART receiver, the ALU and the UART transmitter.
- Collects a 5-byte command frame from the UART receive path and validates it.
- Issues one ALU operation and waits for completion.
- Returns a 4-byte response frame through the UART transmit path, one byte per tx handshake.
- Adds an inter-byte timeout, an ALU watchdog and an error counter.

Parameters:
SYS_CLK, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, UART bit rate; inter-byte timeout = (SYS_CLK/BAUD_RATE)*10*TIMEOUT_BYTES cycles
TIMEOUT_BYTES, 4, inter-byte timeout expressed in byte times
ALU_WAIT_MAX, 255, maximum cycles from alu_start to alu_done before the watchdog fires
SYNC_BYTE, 8'hAA, command frame header
RESP_BYTE, 8'h55, response frame header

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  received byte, valid when rx_complete=1
rx_complete  input  1  one-cycle pulse, byte received
rx_error  input  1  one-cycle pulse, framing error on the receive path
alu_op  output  4  ALU opcode
alu_a  output  8  operand A
alu_b  output  8  operand B
alu_start  output  1  one-cycle start pulse
alu_result  input  16  ALU result, valid when alu_done=1
alu_done  input  1  one-cycle completion pulse
txd  output  8  byte to transmit
tx_en  output  1  one-cycle transmit request
tx_complete  input  1  one-cycle pulse, byte fully transmitted
busy  output  1  high in every state except IDLE
err_cnt  output  8  saturating count of discarded frames

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values:
  - State = IDLE.
  - All outputs 0, including err_cnt and the timeout counter.
  - Assertion mid-frame or mid-transmit aborts immediately; no partial response is sent.
- Command frame: SYNC_BYTE, OP, A, B, CK, where CK = OP^A^B.
- Response frame: RESP_BYTE, STATUS, RES[15:8], RES[7:0].
- Status codes:
  - 00 = ok.
  - 01 = checksum mismatch, RES = 0.
  - 03 = ALU watchdog, RES = 0.
  - 04 = OP[7:4] != 0 (illegal opcode), RES = 0; the ALU is not started.
  - If both 01 and 04 apply, 01 wins.
- States:
  - IDLE: on rx_complete with SYNC_BYTE -> GET_OP. Any other byte is ignored silently.
  - GET_OP, GET_A, GET_B, GET_CK: each rx_complete latches the byte and advances one state.
  - After GET_CK: go to ALU_RUN if status is 00, otherwise to TX_LOAD with the error status.
  - ALU_RUN: alu_start is high for exactly the first cycle. alu_op, alu_a and alu_b are stable from that cycle until alu_done.
  - On alu_done: latch alu_result -> TX_LOAD.
  - Watchdog counts from alu_start; on reaching ALU_WAIT_MAX -> TX_LOAD with status 03. An alu_done in the same cycle takes priority over the watchdog.
  - TX_LOAD: txd = current response byte, tx_en = 1 for one cycle -> TX_WAIT.
  - TX_WAIT: txd held stable. On tx_complete: byte index++; TX_LOAD if index < 4, else IDLE.
  - Back-to-back transmit spacing: 1 cycle from tx_complete to the next tx_en.
- Inter-byte timeout (GET_OP..GET_CK only):
  - Counter reloads on each accepted byte.
  - On expiry: -> IDLE, err_cnt++, no response.
- rx_error in GET_OP..GET_CK: -> IDLE, err_cnt++, no response.
  - rx_error in IDLE is ignored.
  - rx_error and rx_complete in the same cycle: the error wins and the byte is discarded.
- Bytes arriving in ALU_RUN, TX_LOAD or TX_WAIT are dropped and not counted.
- err_cnt saturates at 8'hFF. Checksum and opcode errors do not increment it, since they produce a response.
- Latency:
  - Last CK byte to alu_start: 1 cycle.
  - alu_done to first tx_en: 1 cycle.

Decomposition:
- Shared package/header holds:
  - State encodings (IDLE, GET_OP, GET_A, GET_B, GET_CK, ALU_RUN, TX_LOAD, TX_WAIT).
  - Status codes (ST_OK=8'h00, ST_CKSUM=8'h01, ST_ALU_TO=8'h03, ST_BADOP=8'h04).
  - SYNC_BYTE and RESP_BYTE defaults.
- Sub-module frame_timeout_counter: a loadable down-counter with an expiry pulse, reused for both the inter-byte timeout and the ALU watchdog. Parameterised on width and load value.

Test Plan:
- Valid add: AA 01 12 34 27, ALU returns 0046 after 3 cycles -> alu_start once with op=1, a=12, b=34; tx bytes 55 00 00 46; busy low after the 4th tx_complete.
- Bad checksum: AA 01 12 34 00 -> no alu_start; tx bytes 55 01 00 00; err_cnt unchanged.
- Illegal opcode: AA 10 12 34 36 -> no alu_start; tx bytes 55 04 00 00.
- Mid-frame faults: AA 01 then silence beyond the timeout -> IDLE, err_cnt=1, no tx_en. Separately, rx_error coincident with the 4th byte -> IDLE, err_cnt=2.
- ALU hang: valid frame, alu_done never asserted -> after ALU_WAIT_MAX cycles, tx bytes 55 03 00 00. Bytes injected during TX_WAIT are ignored.
- Reset during TX_WAIT of the 2nd response byte -> all outputs 0 asynchronously. A following valid frame produces a complete, correct response.
